mem_access_ctrl: RTL
====================

// Module: mem_access_ctrl
// PURPOSE
//  Multicycle memory access sequencer sitting directly downstream of the IorD address mux.
//  Takes the selected address (PC or AluOut) plus store data from the B register and runs one
//  complete access against the synchronous data/instruction memory.
//  Performs word/half/byte loads (sign/zero extend) into MDR and word/half/byte stores
//  (read-modify-write for sub-word), and reports completion to the control unit.
// PARAMETERS
//  MEM_LAT   1   memory read latency in cycles, counted from mem_addr stable to mem_rdata valid; legal >=1
//  ADDR_W    32  address width
// PORTS
//  clk        in   1       single clock, rising edge
//  reset_n    in   1       asynchronous, active-low reset
//  start      in   1       begin access; sampled only in IDLE
//  we         in   1       1 = store, 0 = load
//  size       in   2       00 word, 01 half, 10 byte, 11 reserved (treated as misaligned)
//  sign_ext   in   1       loads only: 1 = sign-extend sub-word, 0 = zero-extend
//  addr       in   ADDR_W  byte address from IorD mux
//  wdata      in   32      store data; low bits are used for sub-word stores
//  mem_rdata  in   32      memory read data
//  mem_addr   out  ADDR_W  word-aligned address to memory: {addr_q[ADDR_W-1:2],2'b00}
//  mem_wr     out  1       memory write strobe, one cycle
//  mem_wdata  out  32      full word to write
//  mdr        out  32      memory data register (load result)
//  busy       out  1       high in every state except IDLE
//  done       out  1       one-cycle completion pulse
//  err        out  1       high with done on misaligned or reserved access
// BEHAVIOUR
//  - Reset (async, reset_n=0): state IDLE; addr_q, wdata_q, mdr, mem_wdata = 0; mem_wr, done, err, busy = 0.
//  - Reset mid-access aborts at once. No write is issued after reset_n falls.
//  - Byte lanes are little-endian: offset 0 = bits[7:0] and offset 3 = bits[31:24]. Half at offset 2 = bits[31:16].
//  - FSM states: IDLE, RD, WR, DONE, ERR.
//    - IDLE: on start, latch addr, wdata, we, size, sign_ext.
//      - Misaligned access -> ERR. This is half with addr[0]=1, word with addr[1:0]!=0, or size=11.
//      - Word store -> WR.
//      - Any load or sub-word store -> RD, with cnt = MEM_LAT-1.
//    - RD: mem_wr=0. Decrement cnt. When cnt==0, capture mem_rdata.
//      - Load -> DONE; mdr is updated with the extracted/extended value on this same edge.
//      - Sub-word store -> WR; the merged word is registered into mem_wdata with only the
//        addressed lane(s) replaced.
//    - WR: mem_wr=1 for exactly one cycle. mem_wdata is wdata_q (word) or the merged word -> DONE.
//    - DONE: done=1, err=0 -> IDLE.
//    - ERR: done=1, err=1, no memory read or write issued -> IDLE. mdr is unchanged.
//  - Latency, with start sampled at edge t:
//    - load: done at cycle t+1+MEM_LAT
//    - word store: mem_wr at t+1, done at t+2
//    - sub-word store: mem_wr at t+1+MEM_LAT, done at t+2+MEM_LAT
//    - error: done at t+1
//  - mdr holds its value across stores and errors; it changes only at load completion.
//  - start while busy is ignored, not queued. start held high re-triggers in the cycle after DONE/ERR (IDLE).
//  - mem_addr is stable for the whole access. Inputs may change after the start cycle.
// STRUCTURE
//  - Shared package mem_pkg:
//    - SIZE_WORD/SIZE_HALF/SIZE_BYTE localparams
//    - FSM state encoding localparams
//    - lane helper constants
//  - One combinational sub-module, ls_align, provides:
//    - extract(rdata, off, size, sign_ext) -> 32b
//    - merge(rdata, wdata, off, size) -> 32b
//  - FSM, latency counter and registers stay in mem_access_ctrl.
// TESTING
//  1. Word load: MEM_LAT=1, mem[0x10]=0xDEADBEEF, addr=0x10, we=0, size=00
//     -> done at t+2, mdr=0xDEADBEEF, mem_wr never high.
//  2. Byte load sign/zero: mem[0x20]=0x1234_80FF, addr=0x21, size=10
//     -> sign_ext=1: mdr=0xFFFFFF80; sign_ext=0: mdr=0x00000080.
//  3. Half store RMW: mem[0x30]=0xAABBCCDD, addr=0x32, wdata=0x00001122, size=01, we=1
//     -> one mem_wr with mem_wdata=0x1122CCDD, done at t+3.
//  4. Misaligned: addr=0x41, size=00 -> done=err=1 at t+1, no mem_wr, mdr unchanged.
//  5. MEM_LAT=3 word load with start pulsed again while busy
//     -> second start ignored, done exactly at t+4, busy low only after DONE.
//  6. reset_n=0 during RD of a sub-word store -> all outputs 0 immediately, mem_wr never asserted, FSM in IDLE.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the load/store access sequencer: size codes, FSM states
// and byte-lane helpers.
package mem_pkg;

  localparam logic [1:0] SIZE_WORD = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_BYTE = 2'b10;
  localparam logic [1:0] SIZE_RSVD = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_WR   = 3'd2,
    ST_DONE = 3'd3,
    ST_ERR  = 3'd4
  } state_e;

  localparam logic [31:0] LANE_MASK_BYTE = 32'h0000_00FF;
  localparam logic [31:0] LANE_MASK_HALF = 32'h0000_FFFF;
  localparam logic [31:0] LANE_MASK_WORD = 32'hFFFF_FFFF;

  // Reserved size is always rejected; bytes can never be misaligned.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SIZE_WORD: return (off != 2'b00);
      SIZE_HALF: return off[0];
      SIZE_BYTE: return 1'b0;
      default:   return 1'b1;
    endcase
  endfunction

  function automatic logic [31:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SIZE_BYTE: return LANE_MASK_BYTE << {off, 3'b000};
      SIZE_HALF: return LANE_MASK_HALF << {off, 3'b000};
      default:   return LANE_MASK_WORD;
    endcase
  endfunction

endpackage

// File: rtl/ls_align.sv
// Little-endian lane alignment: extracts a sign/zero-extended sub-word from a read
// word and merges store data into the addressed lane(s) of a read word.
module ls_align
  import mem_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [31:0] wdata_i,
  input  logic [1:0]  off_i,
  input  logic [1:0]  size_i,
  input  logic        sign_ext_i,
  output logic [31:0] extract_o,
  output logic [31:0] merged_o
);

  logic [4:0]  sh_s;
  logic [31:0] shifted_s;
  logic [31:0] mask_s;

  // Lane shift, extend and merge.
  always_comb begin
    sh_s      = {off_i, 3'b000};
    shifted_s = rdata_i >> sh_s;
    mask_s    = lane_mask(size_i, off_i);
    merged_o  = (rdata_i & ~mask_s) | ((wdata_i << sh_s) & mask_s);
    case (size_i)
      SIZE_BYTE: extract_o = sign_ext_i ? {{24{shifted_s[7]}}, shifted_s[7:0]}
                                        : {24'h00_0000, shifted_s[7:0]};
      SIZE_HALF: extract_o = sign_ext_i ? {{16{shifted_s[15]}}, shifted_s[15:0]}
                                        : {16'h0000, shifted_s[15:0]};
      default:   extract_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Multicycle memory access sequencer: one word/half/byte load or store per start,
// sub-word stores done as read-modify-write, completion reported via done/err.
module mem_access_ctrl
  import mem_pkg::*;
#(
  parameter int MEM_LAT = 1,
  parameter int ADDR_W  = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              we,
  input  logic [1:0]        size,
  input  logic              sign_ext,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  input  logic [31:0]       mem_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wr,
  output logic [31:0]       mem_wdata,
  output logic [31:0]       mdr,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              we_q, we_d;
  logic [1:0]        size_q, size_d;
  logic              sext_q, sext_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       mdr_q, mdr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic              mem_wr_q, mem_wr_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [31:0]       extract_s, merged_s;

  ls_align u_align (
    .rdata_i    (mem_rdata),
    .wdata_i    (wdata_q),
    .off_i      (addr_q[1:0]),
    .size_i     (size_q),
    .sign_ext_i (sext_q),
    .extract_o  (extract_s),
    .merged_o   (merged_s)
  );

  // Next state, datapath updates and the flag values for the state being entered.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    we_d        = we_q;
    size_d      = size_q;
    sext_d      = sext_q;
    cnt_d       = cnt_q;
    mdr_d       = mdr_q;
    mem_wdata_d = mem_wdata_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          addr_d  = addr;
          wdata_d = wdata;
          we_d    = we;
          size_d  = size;
          sext_d  = sign_ext;
          if (misaligned(size, addr[1:0])) begin
            state_d = ST_ERR;
          end else if (we && (size == SIZE_WORD)) begin
            state_d     = ST_WR;
            mem_wdata_d = wdata;
          end else begin
            state_d = ST_RD;
            cnt_d   = CNT_INIT;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RD: begin
        if (cnt_q == CNT_ZERO) begin
          if (we_q) begin
            state_d     = ST_WR;
            mem_wdata_d = merged_s;
          end else begin
            state_d = ST_DONE;
            mdr_d   = extract_s;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ST_WR:   state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    mem_wr_d = (state_d == ST_WR);
    busy_d   = (state_d != ST_IDLE);
    done_d   = (state_d == ST_DONE) || (state_d == ST_ERR);
    err_d    = (state_d == ST_ERR);
  end

  // State and output registers; reset aborts any access in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      wdata_q     <= 32'h0000_0000;
      we_q        <= 1'b0;
      size_q      <= SIZE_WORD;
      sext_q      <= 1'b0;
      cnt_q       <= CNT_ZERO;
      mdr_q       <= 32'h0000_0000;
      mem_wdata_q <= 32'h0000_0000;
      mem_wr_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      we_q        <= we_d;
      size_q      <= size_d;
      sext_q      <= sext_d;
      cnt_q       <= cnt_d;
      mdr_q       <= mdr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wr_q    <= mem_wr_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign mem_addr  = {addr_q[ADDR_W-1:2], 2'b00};
  assign mem_wr    = mem_wr_q;
  assign mem_wdata = mem_wdata_q;
  assign mdr       = mdr_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule
